// File: rtl/lite_cfg_seq.sv
// Programs one transfer into a downstream AXI-Lite write controller as a fixed register-write sequence.
// Optional build macro LITE_CFG_SOFT_RESET_EN prepends a soft-reset write to every sequence.
module lite_cfg_seq #(
  parameter int unsigned TIMEOUT_CYC = 256,
  parameter logic [31:0] CR_VALUE    = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_start,
  input  logic [31:0] cfg_src_addr,
  input  logic [31:0] cfg_dst_addr,
  input  logic [25:0] cfg_btt,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic [9:0]  lite_awaddr,
  output logic [31:0] lite_wdata,
  output logic        lite_valid,
  input  logic        lite_end
);

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BTT_W  = 26;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYC) + 1;
`ifdef LITE_CFG_SOFT_RESET_EN
  localparam int unsigned NUM_WR = 5;
`else
  localparam int unsigned NUM_WR = 4;
`endif

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WR - 1);
  localparam logic [TMR_W-1:0] TMR_TERM = TMR_W'(TIMEOUT_CYC - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_GAP   = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [DATA_W-1:0] src_q, src_d;
  logic [DATA_W-1:0] dst_q, dst_d;
  logic [BTT_W-1:0]  btt_q, btt_d;

  logic              issue_nxt;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Next-state logic; lite_end is only honoured in ISSUE and wins over the timeout.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmr_d   = tmr_q;
    src_d   = src_q;
    dst_d   = dst_q;
    btt_d   = btt_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          if (cfg_btt != '0) begin
            src_d   = cfg_src_addr;
            dst_d   = cfg_dst_addr;
            btt_d   = cfg_btt;
            idx_d   = '0;
            tmr_d   = '0;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_ISSUE: begin
        if (lite_end) begin
          state_d = (idx_q == LAST_IDX) ? ST_DONE : ST_GAP;
        end else if (tmr_q == TMR_TERM) begin
          state_d = ST_ERR;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_GAP: begin
        idx_d   = idx_q + IDX_W'(1);
        tmr_d   = '0;
        state_d = ST_ISSUE;
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Register/data pair for the write about to be presented.
  always_comb begin
    wr_addr = '0;
    wr_data = '0;
`ifdef LITE_CFG_SOFT_RESET_EN
    case (idx_d)
      3'd0: begin wr_addr = 10'h000; wr_data = 32'h0000_0004; end
      3'd1: begin wr_addr = 10'h000; wr_data = CR_VALUE; end
      3'd2: begin wr_addr = 10'h018; wr_data = src_d; end
      3'd3: begin wr_addr = 10'h020; wr_data = dst_d; end
      default: begin wr_addr = 10'h028; wr_data = {6'b0, btt_d}; end
    endcase
`else
    case (idx_d)
      3'd0: begin wr_addr = 10'h000; wr_data = CR_VALUE; end
      3'd1: begin wr_addr = 10'h018; wr_data = src_d; end
      3'd2: begin wr_addr = 10'h020; wr_data = dst_d; end
      default: begin wr_addr = 10'h028; wr_data = {6'b0, btt_d}; end
    endcase
`endif
  end

  assign issue_nxt = (state_d == ST_ISSUE);

  // State plus outputs registered from the next state, so outputs track the state register exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      tmr_q       <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      btt_q       <= '0;
      cfg_busy    <= 1'b0;
      cfg_done    <= 1'b0;
      cfg_err     <= 1'b0;
      lite_valid  <= 1'b0;
      lite_awaddr <= '0;
      lite_wdata  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tmr_q       <= tmr_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      btt_q       <= btt_d;
      cfg_busy    <= (state_d != ST_IDLE);
      cfg_done    <= (state_d == ST_DONE);
      cfg_err     <= (state_d == ST_ERR);
      lite_valid  <= issue_nxt;
      lite_awaddr <= issue_nxt ? wr_addr : '0;
      lite_wdata  <= issue_nxt ? wr_data : '0;
    end
  end

endmodule

// File: tb/tb_lite_cfg_seq.sv
// Self-checking bench for lite_cfg_seq: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_lite_cfg_seq;

  localparam int unsigned TMO = 256;
  localparam logic [31:0] CR  = 32'h0000_1000;
`ifdef LITE_CFG_SOFT_RESET_EN
  localparam int NW = 5;
`else
  localparam int NW = 4;
`endif

  logic        clk;
  logic        rst_n;
  logic        cfg_start;
  logic [31:0] cfg_src_addr;
  logic [31:0] cfg_dst_addr;
  logic [25:0] cfg_btt;
  logic        cfg_busy;
  logic        cfg_done;
  logic        cfg_err;
  logic [9:0]  lite_awaddr;
  logic [31:0] lite_wdata;
  logic        lite_valid;
  logic        lite_end;

  int checks = 0;
  int errors = 0;

  lite_cfg_seq #(.TIMEOUT_CYC(TMO), .CR_VALUE(CR)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start),
    .cfg_src_addr(cfg_src_addr), .cfg_dst_addr(cfg_dst_addr), .cfg_btt(cfg_btt),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .lite_awaddr(lite_awaddr), .lite_wdata(lite_wdata), .lite_valid(lite_valid),
    .lite_end(lite_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {awaddr, wdata} of the n-th write of a sequence.
  function automatic logic [41:0] exp_wr(input int n, input logic [31:0] s,
                                         input logic [31:0] d, input logic [25:0] b);
    int k;
    k = n;
`ifdef LITE_CFG_SOFT_RESET_EN
    if (n == 0) return {10'h000, 32'h0000_0004};
    k = n - 1;
`endif
    case (k)
      0:       return {10'h000, CR};
      1:       return {10'h018, s};
      2:       return {10'h020, d};
      default: return {10'h028, 6'b0, b};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: where the sequence is, in terms of write number and cycles waited.
  bit          m_busy, m_gap, m_done, m_err;
  int          m_n, m_wait;
  logic [31:0] m_src, m_dst;
  logic [25:0] m_btt;

  initial begin
    m_busy = 0; m_gap = 0; m_done = 0; m_err = 0; m_n = 0; m_wait = 0;
    m_src = '0; m_dst = '0; m_btt = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_busy = 0; m_gap = 0; m_done = 0; m_err = 0; m_n = 0; m_wait = 0;
        m_src = '0; m_dst = '0; m_btt = '0;
      end else if (!m_busy) begin
        if (cfg_start) begin
          m_busy = 1;
          if (cfg_btt == 0) m_err = 1;
          else begin
            m_src = cfg_src_addr; m_dst = cfg_dst_addr; m_btt = cfg_btt;
            m_n = 0; m_wait = 0; m_gap = 0;
          end
        end
      end else if (m_done || m_err) begin
        m_busy = 0; m_done = 0; m_err = 0;
      end else if (m_gap) begin
        m_gap = 0; m_n++; m_wait = 0;
      end else if (lite_end) begin
        if (m_n == NW - 1) m_done = 1;
        else m_gap = 1;
      end else if (m_wait == TMO - 1) begin
        m_err = 1;
      end else begin
        m_wait++;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    logic        ev;
    logic [45:0] exp_v, act_v;
    forever begin
      @(negedge clk);
      ev    = m_busy && !m_gap && !m_done && !m_err;
      exp_v = {m_busy, m_done, m_err, ev, ev ? exp_wr(m_n, m_src, m_dst, m_btt) : 42'b0};
      act_v = {cfg_busy, cfg_done, cfg_err, lite_valid, lite_awaddr, lite_wdata};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_cmp at %0t: got {busy,done,err,valid,addr,data}=%h expected %h",
                 $time, act_v, exp_v);
      end
    end
  end

  // Downstream responder: rmode 0 = fixed delay, 1 = random delay, 2 = never respond.
  int rmode  = 0;
  int rdelay = 3;
  bit stray  = 0;
  initial begin
    int k;
    bit pv;
    k = 0; pv = 0; lite_end = 1'b0;
    forever begin
      @(negedge clk);
      if (lite_valid) begin
        if (!pv) begin
          k = 0;
          if (rmode == 1) rdelay = ($urandom_range(0, 19) == 0) ? 300 : int'($urandom_range(0, 6));
        end else k++;
      end
      lite_end = lite_valid ? (rmode != 2 && k == rdelay) : (stray && $urandom_range(0, 3) == 0);
      pv = lite_valid;
    end
  end

  // Monitor: writes presented, pulses and ISSUE cycles seen.
  logic [41:0] wq[$];
  int n_done, n_err, n_vcyc;
  initial begin
    bit mpv;
    mpv = 0; n_done = 0; n_err = 0; n_vcyc = 0;
    forever begin
      @(negedge clk);
      if (lite_valid && !mpv) wq.push_back({lite_awaddr, lite_wdata});
      if (cfg_done) n_done++;
      if (cfg_err) n_err++;
      if (lite_valid) n_vcyc++;
      mpv = lite_valid;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wq.delete();
    n_done = 0; n_err = 0; n_vcyc = 0;
  endtask

  task automatic start(input logic [31:0] s, input logic [31:0] d, input logic [25:0] b);
    cfg_src_addr = s; cfg_dst_addr = d; cfg_btt = b; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && cfg_busy; i++) tick();
    chk("idle_within_budget", cfg_busy, 1'b0);
  endtask

  initial begin
    logic [41:0] lit[5];
    logic [31:0] a, b;
    logic [25:0] c;
    int off, cyc;

    off = 0;
`ifdef LITE_CFG_SOFT_RESET_EN
    lit[0] = {10'h000, 32'h0000_0004};
    off = 1;
`endif
    lit[off + 0] = {10'h000, 32'h0000_1000};
    lit[off + 1] = {10'h018, 32'h1000_0000};
    lit[off + 2] = {10'h020, 32'h2000_0000};
    lit[off + 3] = {10'h028, 32'h0000_1000};

    rst_n = 1'b0; cfg_start = 1'b0; cfg_src_addr = '0; cfg_dst_addr = '0; cfg_btt = '0;
    repeat (3) tick();
    chk("reset_outputs", {cfg_busy, cfg_done, cfg_err, lite_valid, lite_awaddr, lite_wdata}, '0);
    rst_n = 1'b1;
    tick();

    // Nominal sequence, response three cycles after each rise.
    clear_mon(); rmode = 0; rdelay = 3;
    start(32'h1000_0000, 32'h2000_0000, 26'd4096);
    chk("valid_at_cycle1", lite_valid, 1'b1);
    cyc = 1;
    while (!cfg_done && cyc < 100) begin tick(); cyc++; end
    chk("done_cycle", cyc, 5 * NW);
    chk("write_count", wq.size(), NW);
    for (int i = 0; i < NW; i++) chk($sformatf("write_%0d", i), (i < wq.size()) ? wq[i] : '0, lit[i]);
    tick();
    chk("single_done", n_done, 1);
    chk("busy_after_done", cfg_busy, 1'b0);

    // Zero byte count is rejected with no write.
    clear_mon();
    start(32'hAAAA_0000, 32'hBBBB_0000, 26'd0);
    chk("err_at_cycle1", cfg_err, 1'b1);
    tick();
    chk("err_one_cycle", {cfg_err, cfg_busy}, 2'b00);
    chk("no_write_on_reject", n_vcyc, 0);

    // No response: timeout after exactly TMO ISSUE cycles.
    clear_mon(); rmode = 2;
    start(32'h1234_5678, 32'h9ABC_DEF0, 26'd77);
    wait_idle(400);
    chk("timeout_valid_cycles", n_vcyc, TMO);
    chk("timeout_err_pulses", n_err, 1);
    chk("timeout_no_done", n_done, 0);

    // Response on the terminal timeout cycle wins.
    clear_mon(); rmode = 0; rdelay = TMO - 1;
    start(32'h0000_1111, 32'h0000_2222, 26'd3);
    wait_idle(5 * TMO);
    chk("terminal_end_no_err", n_err, 0);
    chk("terminal_end_done", n_done, 1);
    chk("terminal_end_writes", wq.size(), NW);

    // Restarts and stray responses during the sequence are ignored.
    clear_mon(); rmode = 0; rdelay = 1; stray = 1;
    a = $urandom; b = $urandom; c = 26'($urandom) | 26'd1;
    start(a, b, c);
    for (int i = 0; i < 100 && !cfg_done; i++) begin
      cfg_start = 1'b1; cfg_src_addr = $urandom; cfg_dst_addr = $urandom; cfg_btt = 26'($urandom);
      tick();
    end
    cfg_start = 1'b0; stray = 0;
    wait_idle(10);
    chk("ignore_write_count", wq.size(), NW);
    for (int i = 0; i < NW; i++)
      chk($sformatf("ignore_write_%0d", i), (i < wq.size()) ? wq[i] : '0, exp_wr(i, a, b, c));
    chk("ignore_single_done", n_done, 1);

    // Reset during the third write aborts silently.
    clear_mon(); rmode = 0; rdelay = 2;
    start(32'hCAFE_0000, 32'hBEEF_0000, 26'd64);
    for (int i = 0; i < 100 && wq.size() < 3; i++) tick();
    chk("third_write_reached", wq.size(), 3);
    rst_n = 1'b0;
    tick();
    chk("reset_drops_valid", {lite_valid, cfg_busy}, 2'b00);
    rst_n = 1'b1;
    repeat (5) tick();
    chk("reset_no_pulses", n_done + n_err, 0);

    // Randomized traffic, checked by the every-cycle model.
    clear_mon(); rmode = 1;
    for (int i = 0; i < 3000; i++) begin
      cfg_start    = ($urandom_range(0, 9) == 0);
      cfg_btt      = ($urandom_range(0, 4) == 0) ? 26'd0 : 26'($urandom);
      cfg_src_addr = $urandom;
      cfg_dst_addr = $urandom;
      rst_n        = ($urandom_range(0, 199) != 0);
      stray        = $urandom_range(0, 1) == 1;
      tick();
    end
    rst_n = 1'b1; cfg_start = 1'b0; stray = 0;
    wait_idle(2000);
    chk("random_done_seen", n_done > 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lite_cfg_seq.md
LITE_CFG_SEQ -- requirements
Module: lite_cfg_seq

Interface
REQ-001 Parameter TIMEOUT_CYC, default 256: the maximum number of cycles one write may stay outstanding before it is aborted.
REQ-002 Parameter CR_VALUE, default 32'h0000_1000: the data value written to the control register (IOC_IrqEn set).
REQ-003 clk  input  1  single system clock; all logic on the rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 cfg_start  input  1  one-cycle request to program one transfer.
REQ-006 cfg_src_addr  input  32  source address.
REQ-007 cfg_dst_addr  input  32  destination address.
REQ-008 cfg_btt  input  26  bytes to transfer.
REQ-009 cfg_busy  output  1  high while a sequence is in progress (any state other than IDLE).
REQ-010 cfg_done  output  1  one-cycle pulse when the full sequence has completed.
REQ-011 cfg_err  output  1  one-cycle pulse on rejection or timeout.
REQ-012 lite_awaddr  output  10  register address, to the downstream AXI-Lite write controller.
REQ-013 lite_wdata  output  32  register data, to the downstream controller.
REQ-014 lite_valid  output  1  write request, to the downstream controller.
REQ-015 lite_end  input  1  one-cycle pulse from the downstream controller when the write response completes.

Function
REQ-016 The FSM SHALL have the states IDLE, ISSUE, GAP, DONE and ERR; state is registered, and lite_valid, cfg_done and cfg_err SHALL be decoded from the registered state (Moore outputs).
REQ-017 In IDLE, cfg_start=1 with cfg_btt!=0 SHALL:
- latch src, dst and btt;
- clear the write index;
- move to ISSUE on the next edge.
REQ-018 In IDLE, cfg_start=1 with cfg_btt==0 SHALL go to ERR with no write issued.
REQ-019 The write sequence SHALL be, in index order:
- 0: awaddr 10'h000, data CR_VALUE;
- 1: awaddr 10'h018, data src;
- 2: awaddr 10'h020, data dst;
- 3: awaddr 10'h028, data {6'b0, btt}.
REQ-020 lite_valid SHALL be 1 exactly while in ISSUE; lite_awaddr and lite_wdata SHALL be stable for the whole ISSUE period.
REQ-021 In ISSUE, lite_end=1 SHALL go to DONE if the index is the last one, and otherwise to GAP.
REQ-022 GAP SHALL last exactly one cycle with lite_valid=0, increment the index, and return to ISSUE.
REQ-023 The timeout counter SHALL clear on entry to ISSUE and increment on every ISSUE cycle; when it reaches TIMEOUT_CYC-1 without lite_end, the FSM SHALL go to ERR.
REQ-024 If lite_end and the timeout terminal count occur in the same cycle, lite_end SHALL win.
REQ-025 DONE and ERR SHALL each last one cycle, pulse cfg_done or cfg_err respectively, and then return to IDLE.
REQ-026 cfg_start SHALL be ignored outside IDLE, and latched values SHALL NOT change mid-sequence.
REQ-027 lite_end SHALL be ignored outside ISSUE.
REQ-028 Latency: from cfg_start at cycle 0, lite_valid SHALL rise at cycle 1; a new write SHALL begin 2 cycles after each non-final lite_end; cfg_done SHALL be high the cycle after the final lite_end.
REQ-029 lite_awaddr and lite_wdata SHALL be 0 when not in ISSUE.

Reset
REQ-030 rst_n=0 on a clock edge SHALL force:
- state IDLE;
- index 0;
- timeout counter 0;
- latched registers 0;
- all outputs 0.
REQ-031 Reset mid-sequence SHALL drop lite_valid on the following cycle; no cfg_done or cfg_err is produced for the aborted sequence.

Configuration
REQ-032 Macro LITE_CFG_SOFT_RESET_EN, when defined, SHALL prepend a write of awaddr 10'h000, data 32'h0000_0004 (soft reset) before index 0, giving five writes per sequence.
REQ-033 When LITE_CFG_SOFT_RESET_EN is undefined, exactly the four writes of REQ-019 SHALL be issued.

Verification
REQ-034 Start with src=32'h1000_0000, dst=32'h2000_0000, btt=26'd4096, and lite_end returned 3 cycles after each lite_valid rise -> four writes in the order 000/00001000, 018/10000000, 020/20000000, 028/00001000, then one cfg_done pulse.
REQ-035 Start with btt=0 -> cfg_err pulses at cycle 1, and lite_valid never rises.
REQ-036 lite_end withheld with TIMEOUT_CYC=256 -> lite_valid is high for 256 cycles, then one cfg_err pulse, then cfg_busy=0.
REQ-037 lite_end asserted on the timeout terminal cycle -> the sequence continues to GAP and no cfg_err is produced.
REQ-038 Second cfg_start and a stray lite_end pulse during GAP -> both are ignored and the write order is unchanged.
REQ-039 rst_n=0 during the write at index 2 -> lite_valid=0 and cfg_busy=0 the next cycle, and no cfg_done is produced.
